// File: rtl/aes_job_controller_if.sv
// aes_job_controller_if
//   Bundles the host-side Avalon-MM slave bus and the AES core handshake.
//   slave  : controller view (responds to host, drives the AES core)
//   master : host / core-model view (drives bus requests, returns core results)
//   Signals:
//     avs_address[3:0], avs_write, avs_writedata[31:0], avs_read  host -> ctrl
//     avs_readdata[31:0]                                          ctrl -> host
//     aes_key[127:0], aes_key_load, aes_block_in[127:0], aes_start ctrl -> core
//     aes_key_ready, aes_done, aes_block_out[127:0]                core -> ctrl
interface aes_job_controller_if;
   logic [3:0]   avs_address;
   logic         avs_write;
   logic [31:0]  avs_writedata;
   logic         avs_read;
   logic [31:0]  avs_readdata;
   logic [127:0] aes_key;
   logic         aes_key_load;
   logic         aes_key_ready;
   logic [127:0] aes_block_in;
   logic         aes_start;
   logic         aes_done;
   logic [127:0] aes_block_out;

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata,
      output aes_key, aes_key_load, aes_block_in, aes_start,
      input  aes_key_ready, aes_done, aes_block_out
   );

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata,
      input  aes_key, aes_key_load, aes_block_in, aes_start,
      output aes_key_ready, aes_done, aes_block_out
   );
endinterface

// File: rtl/aes_job_controller.sv
// aes_job_controller
//   Host-facing sequencer for a single-block AES core: loads the key,
//   launches encryptions, supervises the core handshake with a timeout and
//   buffers results in a small FIFO that the host drains over Avalon-MM.
//   Ports:
//     clk        in   single clock
//     rst_n      in   asynchronous active-low reset
//     bus        if   aes_job_controller_if.slave (Avalon-MM + AES core)
//     irq        out  level interrupt
//     debug_data out  {BLKCNT[15:0], fifo count[7:0], 5'b0, state[2:0]}
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   ST_IDLE      | waiting for a CTRL command
//   ST_KEY_LOAD  | aes_key_load pulse to the core
//   ST_KEY_WAIT  | waiting for aes_key_ready or timeout
//   ST_BLK_START | aes_start pulse to the core
//   ST_BLK_WAIT  | waiting for aes_done or timeout
module aes_job_controller #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_job_controller_if.slave  bus,
   output logic                 irq,
   output logic [31:0]          debug_data
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_KEY_LOAD  = 3'd1,
      ST_KEY_WAIT  = 3'd2,
      ST_BLK_START = 3'd3,
      ST_BLK_WAIT  = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic           r_irq_en;
   logic [127:0]   r_key;
   logic [127:0]   r_din;
   logic [127:0]   r_block_in;
   logic           r_key_valid;
   logic           r_timeout_err;
   logic           r_done_flag;
   logic           r_reject_err;
   logic [31:0]    r_blkcnt;
   logic [31:0]    r_readdata;
   logic [TW-1:0]  r_tmo_cnt;

   logic [127:0]   r_fifo [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   logic           w_ctrl_wr;
   logic           w_status_wr;
   logic           w_key_wr;
   logic           w_abort;
   logic           w_full;
   logic           w_empty;
   logic           w_busy;
   logic           w_pop;
   logic           w_push;
   logic           w_launch;
   logic           w_key_req;
   logic           w_key_ok;
   logic           w_reject;
   logic           w_timeout;
   logic           w_tmo_tc;
   logic [7:0]     w_count8;
   logic [127:0]   w_head;
   logic [31:0]    w_rd_mux;

   assign w_ctrl_wr   = bus.avs_write && (bus.avs_address == 4'd0);
   assign w_status_wr = bus.avs_write && (bus.avs_address == 4'd1);
   assign w_key_wr    = bus.avs_write && (bus.avs_address >= 4'd2) && (bus.avs_address <= 4'd5);
   assign w_abort     = w_ctrl_wr && bus.avs_writedata[2];
   assign w_full      = (r_count == FULL_CNT);
   assign w_empty     = (r_count == '0);
   assign w_busy      = (r_state != ST_IDLE);
   assign w_pop       = bus.avs_read && (bus.avs_address == 4'd13) && !w_empty;
   assign w_tmo_tc    = (r_tmo_cnt == '0);
   assign w_count8    = 8'(r_count);
   assign w_head      = w_empty ? 128'd0 : r_fifo[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ABORT overrides everything, including a coincident aes_done.
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_key_req   = 1'b0;
      w_key_ok    = 1'b0;
      w_reject    = 1'b0;
      w_timeout   = 1'b0;
      w_push      = 1'b0;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_ctrl_wr) begin
                  if (bus.avs_writedata[1]) begin
                     w_state_nxt = ST_KEY_LOAD;
                     w_key_req   = 1'b1;
                     w_reject    = bus.avs_writedata[0];
                  end else if (bus.avs_writedata[0]) begin
                     if (r_key_valid && !w_full) begin
                        w_state_nxt = ST_BLK_START;
                        w_launch    = 1'b1;
                     end else begin
                        w_reject    = 1'b1;
                     end
                  end
               end
            end
            ST_KEY_LOAD:  w_state_nxt = ST_KEY_WAIT;
            ST_KEY_WAIT: begin
               if (bus.aes_key_ready) begin
                  w_state_nxt = ST_IDLE;
                  w_key_ok    = 1'b1;
               end else if (w_tmo_tc) begin
                  w_state_nxt = ST_IDLE;
                  w_timeout   = 1'b1;
               end
            end
            ST_BLK_START: w_state_nxt = ST_BLK_WAIT;
            ST_BLK_WAIT: begin
               if (bus.aes_done) begin
                  w_state_nxt = ST_IDLE;
                  w_push      = 1'b1;
               end else if (w_tmo_tc) begin
                  w_state_nxt = ST_IDLE;
                  w_timeout   = 1'b1;
               end
            end
            default:      w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (bus.avs_address)
         4'd0:  w_rd_mux = {28'd0, r_irq_en, 3'd0};
         4'd1:  w_rd_mux = {16'd0, w_count8, 1'b0, r_reject_err, r_done_flag, r_timeout_err,
                           w_full, !w_empty, r_key_valid, w_busy};
         4'd2:  w_rd_mux = r_key[31:0];
         4'd3:  w_rd_mux = r_key[63:32];
         4'd4:  w_rd_mux = r_key[95:64];
         4'd5:  w_rd_mux = r_key[127:96];
         4'd6:  w_rd_mux = r_din[31:0];
         4'd7:  w_rd_mux = r_din[63:32];
         4'd8:  w_rd_mux = r_din[95:64];
         4'd9:  w_rd_mux = r_din[127:96];
         4'd10: w_rd_mux = w_head[31:0];
         4'd11: w_rd_mux = w_head[63:32];
         4'd12: w_rd_mux = w_head[95:64];
         4'd13: w_rd_mux = w_head[127:96];
         4'd14: w_rd_mux = r_blkcnt;
         default: w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_en      <= 1'b0;
         r_key         <= '0;
         r_din         <= '0;
         r_block_in    <= '0;
         r_key_valid   <= 1'b0;
         r_timeout_err <= 1'b0;
         r_done_flag   <= 1'b0;
         r_reject_err  <= 1'b0;
         r_blkcnt      <= '0;
         r_readdata    <= '0;
         r_tmo_cnt     <= '0;
      end else begin
         r_readdata <= bus.avs_read ? w_rd_mux : 32'd0;
         if (w_ctrl_wr) r_irq_en <= bus.avs_writedata[3];
         if (bus.avs_write) begin
            case (bus.avs_address)
               4'd2: r_key[31:0]   <= bus.avs_writedata;
               4'd3: r_key[63:32]  <= bus.avs_writedata;
               4'd4: r_key[95:64]  <= bus.avs_writedata;
               4'd5: r_key[127:96] <= bus.avs_writedata;
               4'd6: r_din[31:0]   <= bus.avs_writedata;
               4'd7: r_din[63:32]  <= bus.avs_writedata;
               4'd8: r_din[95:64]  <= bus.avs_writedata;
               4'd9: r_din[127:96] <= bus.avs_writedata;
               default: ;
            endcase
         end
         if (w_launch) r_block_in <= r_din;

         // W1C clears first so a same-cycle event still sets its flag.
         if (w_status_wr) begin
            if (bus.avs_writedata[4]) r_timeout_err <= 1'b0;
            if (bus.avs_writedata[5]) r_done_flag   <= 1'b0;
            if (bus.avs_writedata[6]) r_reject_err  <= 1'b0;
         end
         if (w_timeout) r_timeout_err <= 1'b1;
         if (w_push)    r_done_flag   <= 1'b1;
         if (w_reject)  r_reject_err  <= 1'b1;

         if (w_key_ok) r_key_valid <= 1'b1;
         if (w_key_req || w_abort || w_key_wr) r_key_valid <= 1'b0;

         if (w_push) r_blkcnt <= r_blkcnt + 32'd1;

         // Reloaded outside the wait states; terminal count at zero gives
         // exactly TIMEOUT cycles in the wait state.
         if ((r_state == ST_KEY_WAIT) || (r_state == ST_BLK_WAIT)) begin
            if (!w_tmo_tc) r_tmo_cnt <= r_tmo_cnt - 1'b1;
         end else begin
            r_tmo_cnt <= TMO_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Storage needs no reset: empty-FIFO reads are masked to zero.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= bus.aes_block_out;
   end

   assign bus.avs_readdata = r_readdata;
   assign bus.aes_key      = r_key;
   assign bus.aes_block_in = r_block_in;
   assign bus.aes_key_load = (r_state == ST_KEY_LOAD);
   assign bus.aes_start    = (r_state == ST_BLK_START);

   assign irq        = r_irq_en && (r_done_flag || r_timeout_err || r_reject_err);
   assign debug_data = {r_blkcnt[15:0], w_count8, 5'd0, r_state};

endmodule

// File: tb/tb_aes_job_controller.sv
// tb_aes_job_controller
//   Directed bench for aes_job_controller; the bench plays host and AES core.
module tb_aes_job_controller;

   logic        clk;
   logic        rst_n;
   logic        irq;
   logic [31:0] debug_data;

   aes_job_controller_if u_if ();

   aes_job_controller #(.FIFO_DEPTH(4), .TIMEOUT(1023)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (u_if),
      .irq        (irq),
      .debug_data (debug_data)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_key_load = 0;
   int n_start    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (u_if.aes_key_load) n_key_load++;
      if (u_if.aes_start)    n_start++;
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
      u_if.avs_address   = a;
      u_if.avs_writedata = d;
      u_if.avs_write     = 1'b1;
      @(posedge clk);
      #1;
      u_if.avs_write     = 1'b0;
   endtask

   task automatic avs_rd(input logic [3:0] a, output logic [31:0] d);
      u_if.avs_address = a;
      u_if.avs_read    = 1'b1;
      @(posedge clk);
      #1;
      u_if.avs_read    = 1'b0;
      d = u_if.avs_readdata;
   endtask

   task automatic core_done(input logic [127:0] blk);
      u_if.aes_block_out = blk;
      u_if.aes_done      = 1'b1;
      cyc(1);
      u_if.aes_done      = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] rd;
      int s0;
      int k0;

      rst_n = 1'b0;
      u_if.avs_address   = '0;
      u_if.avs_write     = 1'b0;
      u_if.avs_writedata = '0;
      u_if.avs_read      = 1'b0;
      u_if.aes_key_ready = 1'b0;
      u_if.aes_done      = 1'b0;
      u_if.aes_block_out = '0;
      cyc(3);
      check_val("rst_outs", {irq, u_if.aes_start, u_if.aes_key_load, debug_data, u_if.avs_readdata}, '0);
      check_val("rst_key", u_if.aes_key, '0);
      check_val("rst_blk", u_if.aes_block_in, '0);
      rst_n = 1'b1;
      cyc(1);

      // ---- key load ----
      avs_wr(4'd2, 32'h0C0D0E0F);
      avs_wr(4'd3, 32'h08090A0B);
      avs_wr(4'd4, 32'h04050607);
      avs_wr(4'd5, 32'h00010203);
      check_val("aes_key", u_if.aes_key, 128'h000102030405060708090A0B0C0D0E0F);
      avs_rd(4'd3, rd);
      check_val("key_rd1", rd, 32'h08090A0B);
      k0 = n_key_load;
      avs_wr(4'd0, 32'h0A);
      check_val("kl_state", debug_data[2:0], 3'd1);
      cyc(1);
      check_val("kw_state", debug_data[2:0], 3'd2);
      cyc(18);
      u_if.aes_key_ready = 1'b1;
      cyc(1);
      u_if.aes_key_ready = 1'b0;
      check_val("kl_pulses", n_key_load - k0, 1);
      check_val("kl_idle", debug_data[2:0], 3'd0);
      avs_rd(4'd1, rd);
      check_val("kl_status", rd, 32'h02);

      // ---- single encrypt ----
      avs_wr(4'd6, 32'hCCDDEEFF);
      avs_wr(4'd7, 32'h8899AABB);
      avs_wr(4'd8, 32'h44556677);
      avs_wr(4'd9, 32'h00112233);
      s0 = n_start;
      avs_wr(4'd0, 32'h09);
      check_val("blk_in", u_if.aes_block_in, 128'h00112233445566778899AABBCCDDEEFF);
      check_val("bs_state", debug_data[2:0], 3'd3);
      cyc(1);
      check_val("bw_state", debug_data[2:0], 3'd4);
      cyc(28);
      core_done(128'h69C4E0D86A7B0430D8CDB78070B4C55A);
      check_val("enc_pulses", n_start - s0, 1);
      check_val("enc_irq", irq, 1'b1);
      check_val("enc_debug", debug_data, 32'h00010100);
      avs_rd(4'd10, rd);
      check_val("dout0", rd, 32'h70B4C55A);
      avs_rd(4'd11, rd);
      check_val("dout1", rd, 32'hD8CDB780);
      avs_rd(4'd12, rd);
      check_val("dout2", rd, 32'h6A7B0430);
      avs_rd(4'd13, rd);
      check_val("dout3", rd, 32'h69C4E0D8);
      avs_rd(4'd14, rd);
      check_val("blkcnt1", rd, 32'd1);
      avs_rd(4'd1, rd);
      check_val("enc_status", rd, 32'h22);
      avs_wr(4'd1, 32'h20);
      check_val("irq_clr", irq, 1'b0);

      // ---- FIFO fill, reject, drain ----
      for (int i = 0; i < 4; i++) begin
         avs_wr(4'd6, 32'(i));
         avs_wr(4'd0, 32'h09);
         cyc(1);
         core_done({4{32'hB000_0000 + 32'(i)}});
      end
      avs_rd(4'd1, rd);
      check_val("full_status", rd, 32'h42E);
      s0 = n_start;
      avs_wr(4'd0, 32'h09);
      cyc(2);
      check_val("rej_nostart", n_start - s0, 0);
      check_val("rej_state", debug_data[2:0], 3'd0);
      avs_rd(4'd1, rd);
      check_val("rej_status", rd, 32'h46E);
      for (int i = 0; i < 4; i++) begin
         avs_rd(4'd13, rd);
         check_val("drain", rd, 32'hB000_0000 + 32'(i));
      end
      avs_rd(4'd13, rd);
      check_val("drain_empty", rd, 32'd0);
      avs_rd(4'd14, rd);
      check_val("blkcnt5", rd, 32'd5);
      avs_wr(4'd1, 32'h70);
      avs_rd(4'd1, rd);
      check_val("w1c_status", rd, 32'h02);

      // ---- block timeout ----
      avs_wr(4'd0, 32'h09);
      cyc(1);
      check_val("to_wait", debug_data[2:0], 3'd4);
      cyc(1022);
      check_val("to_edge_m1", {irq, debug_data[2:0]}, {1'b0, 3'd4});
      cyc(1);
      check_val("to_edge", {irq, debug_data[2:0]}, {1'b1, 3'd0});
      avs_rd(4'd1, rd);
      check_val("to_status", rd, 32'h12);
      cyc(3);
      core_done({4{32'hDEAD_BEEF}});
      avs_rd(4'd1, rd);
      check_val("late_done", rd, 32'h12);
      avs_rd(4'd14, rd);
      check_val("late_blkcnt", rd, 32'd5);
      avs_wr(4'd1, 32'h10);

      // ---- START without key, START+LOAD_KEY, busy ignore ----
      avs_wr(4'd2, 32'h0C0D0E0F);
      avs_rd(4'd1, rd);
      check_val("nokey_status", rd, 32'h00);
      s0 = n_start;
      avs_wr(4'd0, 32'h09);
      cyc(1);
      check_val("nokey_start", {n_start - s0, 29'd0, debug_data[2:0]}, '0);
      avs_rd(4'd1, rd);
      check_val("nokey_rej", rd, 32'h40);
      check_val("nokey_irq", irq, 1'b1);
      avs_wr(4'd1, 32'h40);
      k0 = n_key_load;
      avs_wr(4'd0, 32'h0B);
      check_val("both_state", debug_data[2:0], 3'd1);
      avs_rd(4'd1, rd);
      check_val("both_status", rd, 32'h41);
      avs_wr(4'd1, 32'h40);
      avs_wr(4'd0, 32'h09);
      avs_rd(4'd1, rd);
      check_val("busy_ignore", rd, 32'h01);
      u_if.aes_key_ready = 1'b1;
      cyc(1);
      u_if.aes_key_ready = 1'b0;
      avs_rd(4'd1, rd);
      check_val("both_keyok", rd, 32'h02);
      check_val("both_pulses", n_key_load - k0, 1);

      // ---- ABORT in BLK_WAIT with two queued ----
      for (int i = 0; i < 2; i++) begin
         avs_wr(4'd0, 32'h09);
         cyc(1);
         core_done({4{32'hC000_0000 + 32'(i)}});
      end
      avs_wr(4'd0, 32'h09);
      cyc(1);
      check_val("ab_pre", debug_data, 32'h00070204);
      u_if.aes_block_out = {4{32'h1234_5678}};
      u_if.aes_done      = 1'b1;
      avs_wr(4'd0, 32'h0C);
      u_if.aes_done      = 1'b0;
      check_val("ab_post", debug_data, 32'h00070000);
      avs_rd(4'd1, rd);
      check_val("ab_status", rd, 32'h20);
      avs_rd(4'd13, rd);
      check_val("ab_dout", rd, 32'd0);

      // ---- async reset mid-transaction ----
      avs_wr(4'd0, 32'h0A);
      cyc(2);
      u_if.aes_key_ready = 1'b1;
      cyc(1);
      u_if.aes_key_ready = 1'b0;
      avs_wr(4'd0, 32'h09);
      check_val("pre_rst", {irq, u_if.aes_start}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_outs", {irq, u_if.aes_start, u_if.aes_key_load, debug_data, u_if.avs_readdata}, '0);
      check_val("arst_key", u_if.aes_key, '0);
      check_val("arst_blk", u_if.aes_block_in, '0);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      avs_rd(4'd14, rd);
      check_val("arst_blkcnt", rd, 32'd0);
      avs_rd(4'd1, rd);
      check_val("arst_status", rd, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_job_controller.md
# aes_job_controller

Sequencer that sits between the PCIe host (via an Avalon-MM slave) and the AES core. It loads the 128-bit key, launches single-block encryptions, and supervises the core handshake with a timeout. Results are buffered in a small FIFO for the host to drain. A live status word drives the board debug output.

## Interface
Parameters:
- FIFO_DEPTH, 4, result FIFO depth in 128-bit blocks; power of two, 2..16.
- TIMEOUT, 1023, max cycles waited in KEY_WAIT/BLK_WAIT before error; ≥ 1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- avs_address  in  4  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed latency 1; no waitrequest.
- aes_key  out  128  key to core, driven from KEY registers.
- aes_key_load  out  1  one-cycle key-expansion request.
- aes_key_ready  in  1  level; core key schedule complete.
- aes_block_in  out  128  plaintext, frozen at launch.
- aes_start  out  1  one-cycle block-start pulse.
- aes_done  in  1  one-cycle pulse; aes_block_out valid that cycle.
- aes_block_out  in  128  ciphertext.
- irq  out  1  level interrupt.
- debug_data  out  32  status for board debug.

## Operation
Register map (word address; register word 0 = bits [31:0]):
- 0 CTRL: W bit0 START, bit1 LOAD_KEY, bit2 ABORT (all self-clearing); bit3 IRQ_EN is R/W.
- 1 STATUS, R: bit0 busy, bit1 key_valid, bit2 fifo non-empty, bit3 fifo full, bit4 timeout_err, bit5 done_flag, bit6 reject_err, [15:8] fifo count. W1C on bits 4–6.
- 2–5 KEY words 0..3 (R/W). Any write clears key_valid.
- 6–9 DIN words 0..3 (R/W staging). Writable while busy.
- 10–13 DOUT words 0..3 of the FIFO head. Reading word 13 pops the head; reading an empty FIFO returns 0 and does not pop.
- 14 BLKCNT: 32-bit count of completed blocks, wraps. Cleared by reset only.
- Unmapped reads return 0.

FSM states (debug encoding):
- IDLE=0. LOAD_KEY → KEY_LOAD. START with key_valid and FIFO not full → BLK_START; DIN is copied into aes_block_in on the cycle of the write.
- START is rejected (reject_err set, stay IDLE) if key_valid=0 or the FIFO is full.
- START and LOAD_KEY in the same write: LOAD_KEY wins, START is rejected.
- KEY_LOAD=1: assert aes_key_load for one cycle → KEY_WAIT.
- KEY_WAIT=2: aes_key_ready=1 → set key_valid, go to IDLE.
- BLK_START=3: assert aes_start for one cycle → BLK_WAIT.
- BLK_WAIT=4: on aes_done, push aes_block_out, BLKCNT+1, set done_flag, go to IDLE.
- In KEY_WAIT and BLK_WAIT, a timeout counter reaching TIMEOUT sets timeout_err and returns to IDLE. A KEY_WAIT timeout also leaves key_valid=0.
- CTRL writes other than ABORT are ignored while busy (busy = state≠IDLE). They do not set reject_err.
- ABORT (any state): go to IDLE next cycle, flush the FIFO, clear key_valid. Errors and flags are unchanged. An aes_done arriving outside BLK_WAIT is ignored.
- FIFO: simultaneous push and pop in one cycle leaves the count unchanged and is legal when full. A push can never occur into a full FIFO, because launch is gated.
- irq = IRQ_EN & (done_flag | timeout_err | reject_err).
- debug_data = {BLKCNT[15:0], fifo count zero-extended to 8 bits, 5'b0, state[2:0]}.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, all registers 0, key_valid 0.
- Register write takes effect on the next edge. Read data appears the cycle after avs_read.
- START write at edge N: aes_start high during cycle N+1 (BLK_START).
- aes_done at edge M: the result is readable and fifo count updated from M+1; IDLE at M+1.
- Best-case turnaround from START to the next accepted START: 3 cycles plus core latency.
- Timeout: error is flagged exactly TIMEOUT cycles after entering the wait state with no response.
- If aes_done and ABORT coincide, ABORT wins: no push, no count update.

## Test plan
- Key load: write KEY=0x000102…0F, LOAD_KEY; core model asserts ready after 20 cycles → single aes_key_load pulse, STATUS.key_valid=1, state 0.
- Encrypt: DIN=0x00112233…EEFF, START → aes_block_in matches DIN, one aes_start pulse. Core returns 0x69C4E0D8…C55A after 30 cycles → DOUT equals it, BLKCNT=1, irq=1 with IRQ_EN.
- FIFO fill: 4 blocks with no reads → fifo full. Fifth START sets reject_err with no aes_start. Drain via word 13 returns the blocks in order; a fifth read returns 0.
- Timeout: START with a core that never responds → timeout_err set after 1023 cycles, IDLE. A late aes_done is ignored and the FIFO stays empty.
- START without key, and START+LOAD_KEY together → reject_err each time. In the second case the key load proceeds.
- ABORT in BLK_WAIT with 2 blocks queued → IDLE next cycle, FIFO empty, key_valid=0. A same-cycle aes_done is dropped. Async rst_n mid-wait zeroes all outputs immediately.
